// File: rtl/mmu_arbiter.sv
// mmu_arbiter: arbitrates the D-cache (c0) and I-cache (c1) miss/write-back
// traffic onto one backing port, steering each access to block RAM or to the
// MMIO bus, and returns a single-cycle done pulse to the requesting cache.
module mmu_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 14,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned IO_TIMEOUT  = 255
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              c0_req_read,
  input  logic              c0_req_write,
  input  logic [31:0]       c0_addr,
  input  logic [31:0]       c0_wdata,
  output logic              c0_read_done,
  output logic              c0_write_done,
  output logic [31:0]       c0_rdata,
  input  logic              c1_req_read,
  input  logic              c1_req_write,
  input  logic [31:0]       c1_addr,
  input  logic [31:0]       c1_wdata,
  output logic              c1_read_done,
  output logic              c1_write_done,
  output logic [31:0]       c1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              io_valid,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic              io_ready,
  input  logic [31:0]       io_rdata,
  output logic              bus_err
);

  // One counter serves both the RAM latency wait and the IO timeout.
  localparam int unsigned CNT_MAX = (IO_TIMEOUT > MEM_LATENCY) ? IO_TIMEOUT : MEM_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_ISSUE = 3'd1,
    MEM_WAIT  = 3'd2,
    IO_WAIT   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             last_grant_r;
  logic             client_r;
  logic             write_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      data_r;
  logic             err_r;

  logic             req0_s;
  logic             req1_s;
  logic             grant_s;
  logic             gnt_id_s;
  logic             gnt_write_s;
  logic [31:0]      gnt_addr_s;
  logic [31:0]      gnt_wdata_s;
  logic             gnt_io_s;
  logic             write_next_s;
  logic             mem_last_s;
  logic             io_last_s;
  logic             fin_s;

  // Latched request fields drive the backing ports directly so they stay stable.
  assign mem_addr  = addr_r[ADDR_W+1:2];
  assign mem_wdata = wdata_r;
  assign io_addr   = addr_r;
  assign io_wdata  = wdata_r;

  // Round-robin pick between the two caches and decode of the winning request.
  always_comb begin
    req0_s = c0_req_read | c0_req_write;
    req1_s = c1_req_read | c1_req_write;
    if (req0_s && req1_s) begin
      gnt_id_s = ~last_grant_r;
    end else if (req1_s) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    grant_s = (state_r == IDLE) && (req0_s || req1_s);
    if (gnt_id_s) begin
      gnt_write_s = c1_req_write;
      gnt_addr_s  = c1_addr;
      gnt_wdata_s = c1_wdata;
    end else begin
      gnt_write_s = c0_req_write;
      gnt_addr_s  = c0_addr;
      gnt_wdata_s = c0_wdata;
    end
    gnt_io_s     = (gnt_addr_s >= MMIO_BASE);
    write_next_s = grant_s ? gnt_write_s : write_r;
    mem_last_s   = (cnt_r == MEM_LAST);
    io_last_s    = (cnt_r == IO_LAST);
    fin_s        = (state_r == DONE);
  end

  // Next-state logic; io_ready on the timeout edge still counts as success.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_next_s = gnt_io_s ? IO_WAIT : MEM_ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEM_ISSUE: state_next_s = MEM_WAIT;
      MEM_WAIT: begin
        if (mem_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MEM_WAIT;
        end
      end
      IO_WAIT: begin
        if (io_ready || io_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IO_WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Wait counter restarts on every state change and runs only while waiting.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_next_s != state_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == MEM_WAIT) || (state_r == IO_WAIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Capture the granted request; a simultaneous read+write is taken as a write.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      client_r     <= 1'b0;
      write_r      <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
    end else if (grant_s) begin
      last_grant_r <= gnt_id_s;
      client_r     <= gnt_id_s;
      write_r      <= gnt_write_s;
      addr_r       <= gnt_addr_s;
      wdata_r      <= gnt_wdata_s;
    end
  end

  // Capture read data or the timeout outcome at the end of the wait.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= 32'd0;
      err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            err_r <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (mem_last_s && !write_r) begin
            data_r <= mem_rdata;
          end
        end
        IO_WAIT: begin
          if (io_ready) begin
            if (!write_r) begin
              data_r <= io_rdata;
            end
          end else if (io_last_s) begin
            data_r <= 32'd0;
            err_r  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Backing-port strobes, registered from the next state so they align with it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      io_valid <= 1'b0;
      io_we    <= 1'b0;
    end else begin
      mem_en   <= (state_next_s == MEM_ISSUE);
      mem_we   <= (state_next_s == MEM_ISSUE) && write_next_s;
      io_valid <= (state_next_s == IO_WAIT);
      io_we    <= (state_next_s == IO_WAIT) && write_next_s;
    end
  end

  // Completion pulse to the granted cache only, spanning one full cycle after DONE.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_read_done  <= 1'b0;
      c0_write_done <= 1'b0;
      c1_read_done  <= 1'b0;
      c1_write_done <= 1'b0;
      c0_rdata      <= 32'd0;
      c1_rdata      <= 32'd0;
      bus_err       <= 1'b0;
    end else begin
      c0_read_done  <= fin_s && !client_r && !write_r;
      c0_write_done <= fin_s && !client_r &&  write_r;
      c1_read_done  <= fin_s &&  client_r && !write_r;
      c1_write_done <= fin_s &&  client_r &&  write_r;
      bus_err       <= fin_s && err_r;
      if (fin_s && !client_r && !write_r) begin
        c0_rdata <= data_r;
      end
      if (fin_s && client_r && !write_r) begin
        c1_rdata <= data_r;
      end
    end
  end

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: scoreboard bench with RAM/MMIO device models and a word-level
// reference model of what each cache should get back.
module tb_mmu_arbiter;

  localparam int ML  = 1;
  localparam int IOT = 255;

  logic        sys_clk;
  logic        rst_n;
  logic        c0_req_read, c0_req_write, c1_req_read, c1_req_write;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic        c0_read_done, c0_write_done, c1_read_done, c1_write_done;
  logic [31:0] c0_rdata, c1_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        io_valid, io_we, io_ready, bus_err;
  logic [31:0] io_addr, io_wdata, io_rdata;

  mmu_arbiter #(.MEM_LATENCY(ML), .ADDR_W(14), .MMIO_BASE(32'hFFFF_0000), .IO_TIMEOUT(IOT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .c0_req_read(c0_req_read), .c0_req_write(c0_req_write), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_read_done(c0_read_done), .c0_write_done(c0_write_done), .c0_rdata(c0_rdata),
    .c1_req_read(c1_req_read), .c1_req_write(c1_req_write), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_read_done(c1_read_done), .c1_write_done(c1_write_done), .c1_rdata(c1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_valid(io_valid), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ready(io_ready), .io_rdata(io_rdata), .bus_err(bus_err)
  );

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          order_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_rd[2];
  logic [31:0] model_ram[16384];
  logic [31:0] dev_ram[16384];
  logic [31:0] model_io[16];
  logic [31:0] dev_io[16];
  logic [31:0] rd_pipe[ML];
  int          io_delay_force = -1;
  int          mem_run = 0;
  int          io_run = 0;
  int          last_io_run = 0;
  logic [13:0] last_mem_addr = 14'd0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // RAM device: read data appears ML cycles after the strobe, junk otherwise.
  initial begin
    logic [31:0] v;
    mem_rdata = 32'd0;
    for (int i = 0; i < ML; i++) rd_pipe[i] = 32'd0;
    forever begin
      @(negedge sys_clk);
      mem_rdata = rd_pipe[ML-1];
      for (int i = ML - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      v = $urandom;
      if (mem_en) begin
        if (mem_we) dev_ram[mem_addr] = mem_wdata;
        else        v = dev_ram[mem_addr];
      end
      rd_pipe[0] = v;
    end
  end

  // MMIO device: registers at addr[5:2]; addresses with bit 6 set never answer.
  initial begin
    int io_cnt;
    int io_delay;
    io_ready = 1'b0;
    io_rdata = 32'd0;
    io_cnt   = 0;
    io_delay = 0;
    forever begin
      @(negedge sys_clk);
      if (!io_valid || !rst_n) begin
        io_ready = 1'b0;
        io_cnt   = 0;
        io_delay = (io_delay_force >= 0) ? io_delay_force : int'($urandom_range(0, 4));
      end else if (!io_ready && !io_addr[6]) begin
        if (io_cnt == io_delay) begin
          io_ready = 1'b1;
          if (io_we) begin
            dev_io[io_addr[5:2]] = io_wdata;
            io_rdata = $urandom;
          end else begin
            io_rdata = dev_io[io_addr[5:2]];
          end
        end else begin
          io_cnt++;
        end
      end
    end
  end

  task automatic score(input int c);
    exp_t        e;
    logic        wr;
    logic [31:0] rdata;
    wr    = (c == 0) ? c0_write_done : c1_write_done;
    rdata = (c == 0) ? c0_rdata : c1_rdata;
    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_done client=%0d actual=done required=none", c);
    end else begin
      e = (c == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("c%0d_kind_is_write", c), {31'd0, wr}, {31'd0, e.wr});
      if (!e.wr) begin
        check($sformatf("c%0d_rdata", c), rdata, e.data);
        last_rd[c] = e.data;
      end else begin
        check($sformatf("c%0d_rdata_hold", c), rdata, last_rd[c]);
      end
      check($sformatf("c%0d_bus_err", c), {31'd0, bus_err}, {31'd0, e.err});
      order_q.push_back(c);
    end
  endtask

  // Monitor: pops the scoreboard on every done and watches strobe shapes.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n) begin
        if (c0_read_done || c0_write_done || c1_read_done || c1_write_done)
          check("single_done", 32'(c0_read_done) + 32'(c0_write_done) + 32'(c1_read_done) + 32'(c1_write_done), 32'd1);
        if (c0_read_done || c0_write_done) score(0);
        if (c1_read_done || c1_write_done) score(1);
        if (mem_en) begin
          mem_run++;
          last_mem_addr = mem_addr;
        end else begin
          if (mem_run != 0) check("mem_en_len", 32'(mem_run), 32'd1);
          mem_run = 0;
        end
        if (io_valid) begin
          io_run++;
        end else begin
          if (io_run != 0) last_io_run = io_run;
          io_run = 0;
        end
      end
    end
  end

  // Issue one access from a cache: model the expected reply, then hold until done.
  task automatic access(input int c, input int op, input logic [31:0] a, input logic [31:0] wd,
                        input bit tmo, output int waited);
    exp_t e;
    bit   wr;
    bit   fin;
    wr     = (op != 0);
    e.wr   = wr;
    e.err  = 1'b0;
    e.data = 32'd0;
    if (a >= 32'hFFFF_0000) begin
      if (a[6] || tmo) e.err = 1'b1;
      else if (wr)     model_io[a[5:2]] = wd;
      else             e.data = model_io[a[5:2]];
    end else begin
      if (wr) model_ram[a[15:2]] = wd;
      else    e.data = model_ram[a[15:2]];
    end
    if (c == 0) begin
      q0.push_back(e);
      c0_req_read = (op != 1); c0_req_write = (op != 0); c0_addr = a; c0_wdata = wd;
    end else begin
      q1.push_back(e);
      c1_req_read = (op != 1); c1_req_write = (op != 0); c1_addr = a; c1_wdata = wd;
    end
    waited = 0;
    fin    = 1'b0;
    while (!fin && waited < 1000) begin
      @(negedge sys_clk);
      waited++;
      fin = (c == 0) ? (c0_read_done | c0_write_done) : (c1_read_done | c1_write_done);
    end
    if (c == 0) begin c0_req_read = 1'b0; c0_req_write = 1'b0; end
    else        begin c1_req_read = 1'b0; c1_req_write = 1'b0; end
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_timeout client=%0d actual=no_done required=done", c);
    end
  endtask

  task automatic client_proc(input int c);
    logic [31:0] a;
    int          w;
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        a[31:16] = 16'($urandom_range(0, 32'h0000_FFFE));
        a[15]    = (c == 1);
        a[14:6]  = 9'd0;
      end else begin
        a[31:16] = 16'hFFFF;
        a[6]     = ($urandom_range(0, 11) == 0);
        a[5]     = (c == 1);
      end
      access(c, int'($urandom_range(0, 2)), a, $urandom, 1'b0, w);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 32'({c0_read_done, c0_write_done, c1_read_done, c1_write_done,
                               mem_en, mem_we, io_valid, io_we, bus_err}), 32'd0);
    check({tag, "_c0_rdata"}, c0_rdata, 32'd0);
    check({tag, "_c1_rdata"}, c1_rdata, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_io_addr"}, io_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata | io_wdata, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2;
    rst_n = 1'b0;
    c0_req_read = 1'b0; c0_req_write = 1'b0; c0_addr = 32'd0; c0_wdata = 32'd0;
    c1_req_read = 1'b0; c1_req_write = 1'b0; c1_addr = 32'd0; c1_wdata = 32'd0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    for (int i = 0; i < 16384; i++) begin
      dev_ram[i]   = 32'(i) * 32'h9E37_79B9;
      model_ram[i] = 32'(i) * 32'h9E37_79B9;
    end
    for (int i = 0; i < 16; i++) begin
      dev_io[i]   = 32'(i) * 32'h0101_0101 + 32'd1;
      model_io[i] = 32'(i) * 32'h0101_0101 + 32'd1;
    end
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Ties: first after reset goes to c0; a tie after a c0 grant goes to c1.
    order_q.delete();
    fork
      access(0, 0, 32'h0000_0100, 32'd0, 1'b0, w);
      access(1, 0, 32'h0000_8100, 32'd0, 1'b0, w2);
    join
    check("tie1_count", 32'(order_q.size()), 32'd2);
    check("tie1_first", 32'(order_q[0]), 32'd0);
    check("tie1_second", 32'(order_q[1]), 32'd1);
    access(0, 0, 32'h0000_0104, 32'd0, 1'b0, w);
    order_q.delete();
    fork
      access(0, 0, 32'h0000_0108, 32'd0, 1'b0, w);
      access(1, 0, 32'h0000_8108, 32'd0, 1'b0, w2);
    join
    check("tie2_first", 32'(order_q[0]), 32'd1);
    check("tie2_second", 32'(order_q[1]), 32'd0);

    // Plain RAM read: done three edges after the grant edge.
    dev_ram[4]   = 32'hDEAD_BEEF;
    model_ram[4] = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    access(0, 0, 32'h0000_0010, 32'd0, 1'b0, w);
    check("t1_latency", 32'(w), 32'd4);
    check("t1_mem_addr", 32'(last_mem_addr), 32'd4);

    // Write then a held read of the same word.
    access(0, 1, 32'h0000_0040, 32'h1234_5678, 1'b0, w);
    access(0, 0, 32'h0000_0040, 32'd0, 1'b0, w2);
    check("t3_read_latency", 32'(w2), 32'd4);

    // MMIO read answered after three valid cycles.
    dev_io[1]   = 32'h0000_0055;
    model_io[1] = 32'h0000_0055;
    io_delay_force = 2;
    repeat (2) @(negedge sys_clk);
    access(1, 0, 32'hFFFF_0004, 32'd0, 1'b0, w);
    check("t4_io_valid_len", 32'(last_io_run), 32'd3);

    // MMIO write to a silent device: timeout with bus error.
    io_delay_force = -1;
    access(0, 1, 32'hFFFF_0040, 32'hCAFE_0001, 1'b0, w);
    check("t5_io_valid_len", 32'(last_io_run), 32'(IOT));

    // io_ready on the timeout edge wins; one cycle later it is too late.
    io_delay_force = IOT - 1;
    repeat (2) @(negedge sys_clk);
    access(1, 0, 32'hFFFF_0024, 32'd0, 1'b0, w);
    check("edge_ok_io_len", 32'(last_io_run), 32'(IOT));
    io_delay_force = IOT;
    repeat (2) @(negedge sys_clk);
    access(1, 0, 32'hFFFF_0024, 32'd0, 1'b1, w);
    check("edge_late_io_len", 32'(last_io_run), 32'(IOT));
    io_delay_force = -1;
    repeat (2) @(negedge sys_clk);

    // Randomised traffic from both caches at once.
    fork
      client_proc(0);
      client_proc(1);
    join

    // Reset while the RAM read is in flight.
    access(0, 0, 32'h0000_0010, 32'd0, 1'b0, w);
    c0_req_read = 1'b1;
    c0_addr     = 32'h0000_0020;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b0;
    c0_req_read = 1'b0;
    #1;
    check_all_zero("midreset");
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("midreset_no_done", 32'(q0.size() + q1.size()), 32'd0);
    access(0, 0, 32'h0000_0010, 32'd0, 1'b0, w);
    check("after_reset_latency", 32'(w), 32'd4);
    repeat (3) @(negedge sys_clk);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
